// File: rtl/feppagia_pkg.sv
// Shared sprite/screen geometry and the vertical motion state type used by
// the judge, the movement engine and the renderer.
package feppagia_pkg;

    typedef enum logic [1:0] {
        GROUNDED = 2'd0,
        RISING   = 2'd1,
        FALLING  = 2'd2
    } motion_state_t;

    localparam int SPRITE_W = 42;
    localparam int SPRITE_H = 56;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

endpackage

// File: rtl/frame_tick_gen.sv
// Turns the level frame_clk strobe into a single-Clk tick on its rising edge.
module frame_tick_gen (
    input  logic clk,
    input  logic rst,
    input  logic frame_clk,
    output logic tick
);

    logic frame_clk_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_clk_q <= 1'b0;
        end else begin
            frame_clk_q <= frame_clk;
        end
    end

    assign tick = frame_clk & ~frame_clk_q;

endmodule

// File: rtl/character_motion.sv
// Per-frame sprite movement: walking, jumping, gravity and landing, driven by
// keyboard intent and the judge's {left, right, up, down} blocked flags.
module character_motion
    import feppagia_pkg::*;
#(
    parameter int START_X   = 320,
    parameter int START_Y   = 240,
    parameter int HALF_W    = SPRITE_W / 2,
    parameter int HALF_H    = SPRITE_H / 2,
    parameter int WALK_STEP = 2,
    parameter int JUMP_V    = 12,
    parameter int GRAVITY   = 1,
    parameter int MAX_FALL  = 8
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          frame_clk,
    input  logic          key_left,
    input  logic          key_right,
    input  logic          key_jump,
    input  logic [3:0]    stop_at,
    output logic [9:0]    character_X,
    output logic [9:0]    character_Y,
    output logic          facing_left,
    output logic          on_ground,
    output logic          frame_tick,
    output motion_state_t state_dbg
);

    localparam logic signed [10:0] X_MIN      = 11'(HALF_W);
    localparam logic signed [10:0] X_MAX      = 11'(SCREEN_W - 1 - HALF_W);
    localparam logic signed [10:0] Y_MIN      = 11'(HALF_H);
    localparam logic signed [10:0] Y_MAX      = 11'(SCREEN_H - 1 - HALF_H);
    localparam logic signed [7:0]  JUMP_VY    = 8'(-JUMP_V);
    localparam logic signed [7:0]  GRAV_V     = 8'(GRAVITY);
    localparam logic signed [7:0]  MAX_FALL_V = 8'(MAX_FALL);

    logic                tick;
    motion_state_t       state, state_next;
    logic signed [7:0]   vy, vy_next, vy_inc;
    logic signed [10:0]  move, x_cur, y_cur, vy_ext, x_sum, y_sum;
    logic [9:0]          x_next, y_next;

    frame_tick_gen u_tick (
        .clk       (Clk),
        .rst       (Reset),
        .frame_clk (frame_clk),
        .tick      (tick)
    );

    assign x_cur     = $signed({1'b0, character_X});
    assign y_cur     = $signed({1'b0, character_Y});
    assign vy_ext    = {{3{vy[7]}}, vy};
    assign vy_inc    = vy + GRAV_V;
    assign state_dbg = state;

    // Horizontal: both keys, or the requested side blocked, means no motion.
    always_comb begin
        move = '0;
        if (key_right && !key_left && !stop_at[2]) begin
            move = 11'(WALK_STEP);
        end else if (key_left && !key_right && !stop_at[3]) begin
            move = -11'(WALK_STEP);
        end
        x_sum = x_cur + move;
        if (x_sum < X_MIN) begin
            x_next = 10'(HALF_W);
        end else if (x_sum > X_MAX) begin
            x_next = 10'(SCREEN_W - 1 - HALF_W);
        end else begin
            x_next = x_sum[9:0];
        end
    end

    always_comb begin
        state_next = state;
        vy_next    = vy;
        y_sum      = y_cur;
        case (state)
            GROUNDED: begin
                vy_next = '0;
                if (key_jump && !stop_at[1]) begin
                    state_next = RISING;
                    vy_next    = JUMP_VY;
                end else if (!stop_at[0] && (y_cur < Y_MAX)) begin
                    state_next = FALLING;
                end
            end
            RISING: begin
                if (stop_at[1]) begin
                    state_next = FALLING;
                    vy_next    = '0;
                end else begin
                    y_sum   = y_cur + vy_ext;
                    vy_next = vy_inc;
                    if (!vy_inc[7]) begin
                        state_next = FALLING;
                    end
                end
            end
            FALLING: begin
                if (stop_at[0] || (y_cur >= Y_MAX)) begin
                    state_next = GROUNDED;
                    vy_next    = '0;
                end else begin
                    y_sum   = y_cur + vy_ext;
                    vy_next = (vy_inc > MAX_FALL_V) ? MAX_FALL_V : vy_inc;
                end
            end
            default: begin
                state_next = FALLING;
                vy_next    = '0;
            end
        endcase

        // Hitting the top of the screen ends a jump just like a head bump.
        if (y_sum < Y_MIN) begin
            y_next = 10'(HALF_H);
            if (state == RISING) begin
                vy_next    = '0;
                state_next = FALLING;
            end
        end else if (y_sum > Y_MAX) begin
            y_next = 10'(SCREEN_H - 1 - HALF_H);
        end else begin
            y_next = y_sum[9:0];
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            character_X <= 10'(START_X);
            character_Y <= 10'(START_Y);
            vy          <= '0;
            state       <= FALLING;
            facing_left <= 1'b0;
            on_ground   <= 1'b0;
            frame_tick  <= 1'b0;
        end else begin
            frame_tick <= tick;
            if (tick) begin
                character_X <= x_next;
                character_Y <= y_next;
                vy          <= vy_next;
                state       <= state_next;
                on_ground   <= (state_next == GROUNDED);
                if (move != '0) begin
                    facing_left <= move[10];
                end
            end
        end
    end

endmodule

// File: tb/tb_character_motion.sv
// Bench for character_motion: the bench plays the judge, a reference model
// feeds an expected-result queue, and each scenario task adds targeted checks.
module tb_character_motion;
    import feppagia_pkg::*;

    localparam int W = 24;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          frame_clk;
    logic          key_left, key_right, key_jump;
    logic [3:0]    stop_at;
    logic [9:0]    character_X, character_Y;
    logic          facing_left, on_ground, frame_tick;
    motion_state_t state_dbg;

    logic [W-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    // reference model state: st 0=GROUNDED 1=RISING 2=FALLING
    int m_x, m_y, m_vy, m_st;
    logic m_face;

    character_motion dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_clk   (frame_clk),
        .key_left    (key_left),
        .key_right   (key_right),
        .key_jump    (key_jump),
        .stop_at     (stop_at),
        .character_X (character_X),
        .character_Y (character_Y),
        .facing_left (facing_left),
        .on_ground   (on_ground),
        .frame_tick  (frame_tick),
        .state_dbg   (state_dbg)
    );

    always #5 Clk = ~Clk;

    task automatic model_reset();
        m_x = 320; m_y = 240; m_vy = 0; m_st = 2; m_face = 1'b0;
    endtask

    task automatic model_step(input logic kl, input logic kr, input logic kj, input logic [3:0] s);
        int mv;
        mv = 0;
        if (kr && !kl && !s[2]) mv = 2;
        else if (kl && !kr && !s[3]) mv = -2;
        m_x = m_x + mv;
        if (m_x < 21) m_x = 21;
        if (m_x > 618) m_x = 618;
        if (mv > 0) m_face = 1'b0;
        if (mv < 0) m_face = 1'b1;
        if (m_st == 0) begin
            m_vy = 0;
            if (kj && !s[1]) begin m_st = 1; m_vy = -12; end
            else if (!s[0] && m_y < 451) m_st = 2;
        end else if (m_st == 1) begin
            if (s[1]) begin m_st = 2; m_vy = 0; end
            else begin
                m_y = m_y + m_vy;
                m_vy = m_vy + 1;
                if (m_vy >= 0) m_st = 2;
                if (m_y < 28) begin m_y = 28; m_vy = 0; m_st = 2; end
            end
        end else begin
            if (s[0] || m_y >= 451) begin m_st = 0; m_vy = 0; end
            else begin
                m_y = m_y + m_vy;
                m_vy = (m_vy + 1 > 8) ? 8 : m_vy + 1;
                if (m_y > 451) m_y = 451;
            end
        end
    endtask

    function automatic logic [W-1:0] model_word();
        return {10'(m_x), 10'(m_y), m_face, (m_st == 0), 2'(m_st)};
    endfunction

    function automatic logic [W-1:0] dut_word();
        return {character_X, character_Y, facing_left, on_ground, state_dbg};
    endfunction

    // Drives one frame, then pops the scoreboard when frame_tick shows up.
    task automatic drive_tick(input logic kl, input logic kr, input logic kj, input logic [3:0] s);
        logic [W-1:0] exp_w, got_w;
        logic got;
        @(negedge Clk);
        key_left = kl; key_right = kr; key_jump = kj; stop_at = s;
        frame_clk = 1'b1;
        model_step(kl, kr, kj, s);
        exp_q.push_back(model_word());
        got = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            if (frame_tick === 1'b1) begin got = 1'b1; break; end
        end
        frame_clk = 1'b0;
        exp_w = exp_q.pop_front();
        got_w = dut_word();
        n_cmp++;
        if (!got) begin
            n_err++;
            $display("FAIL tick_timeout: frame_tick got 0 within 4 cycles, required 1");
        end else if (got_w !== exp_w) begin
            n_err++;
            $display("FAIL tick_result: got X=%0d Y=%0d face=%0b gnd=%0b st=%0d required X=%0d Y=%0d face=%0b gnd=%0b st=%0d",
                     got_w[23:14], got_w[13:4], got_w[3], got_w[2], got_w[1:0],
                     exp_w[23:14], exp_w[13:4], exp_w[3], exp_w[2], exp_w[1:0]);
        end
        @(negedge Clk);
        n_cmp++;
        if (frame_tick !== 1'b0 || dut_word() !== exp_w) begin
            n_err++;
            $display("FAIL hold: got tick=%0b word=%h required tick=0 word=%h", frame_tick, dut_word(), exp_w);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1; frame_clk = 1'b0;
        key_left = 1'b0; key_right = 1'b0; key_jump = 1'b0; stop_at = 4'b0000;
        model_reset();
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        repeat (2) @(negedge Clk);
        n_cmp++;
        if (character_X !== 10'd320 || character_Y !== 10'd240 || state_dbg !== FALLING ||
            on_ground !== 1'b0 || facing_left !== 1'b0 || frame_tick !== 1'b0) begin
            n_err++;
            $display("FAIL reset_values: got X=%0d Y=%0d st=%0d gnd=%0b face=%0b tick=%0b required 320 240 2 0 0 0",
                     character_X, character_Y, state_dbg, on_ground, facing_left, frame_tick);
        end
    endtask

    task automatic test_first_ticks();
        drive_tick(0, 0, 0, 4'b0000);
        n_cmp++;
        if (character_Y !== 10'd240) begin n_err++; $display("FAIL first_tick_y: got %0d required 240", character_Y); end
        drive_tick(0, 0, 0, 4'b0000);
        n_cmp++;
        if (character_Y !== 10'd241) begin n_err++; $display("FAIL second_tick_y: got %0d required 241", character_Y); end
    endtask

    task automatic test_free_fall();
        int prev_y, max_step, ticks;
        logic clamped_before;
        prev_y = 241; max_step = 0; ticks = 0; clamped_before = 1'b0;
        while (ticks < 40 && on_ground !== 1'b1) begin
            clamped_before = (character_Y == 10'd451);
            drive_tick(0, 0, 0, 4'b0000);
            if (int'(character_Y) - prev_y > max_step) max_step = int'(character_Y) - prev_y;
            prev_y = int'(character_Y);
            ticks++;
        end
        n_cmp++;
        if (max_step !== 8) begin n_err++; $display("FAIL fall_terminal_step: got %0d required 8", max_step); end
        n_cmp++;
        if (on_ground !== 1'b1 || character_Y !== 10'd451 || !clamped_before) begin
            n_err++;
            $display("FAIL fall_landing: got gnd=%0b Y=%0d clamped_before=%0b required 1 451 1", on_ground, character_Y, clamped_before);
        end
    endtask

    task automatic test_jump();
        int exp_y[7] = '{451, 439, 428, 418, 409, 401, 394};
        drive_tick(0, 0, 1, 4'b0001);
        n_cmp++;
        if (state_dbg !== RISING || on_ground !== 1'b0) begin
            n_err++; $display("FAIL jump_start: got st=%0d gnd=%0b required 1 0", state_dbg, on_ground);
        end
        for (int i = 0; i < 7; i++) begin
            if (i > 0) drive_tick(0, 0, 0, 4'b0000);
            n_cmp++;
            if (character_Y !== 10'(exp_y[i])) begin
                n_err++; $display("FAIL jump_y[%0d]: got %0d required %0d", i, character_Y, exp_y[i]);
            end
        end
    endtask

    task automatic test_head_hit();
        drive_tick(0, 0, 0, 4'b0010);
        n_cmp++;
        if (state_dbg !== FALLING || character_Y !== 10'd394) begin
            n_err++; $display("FAIL head_hit: got st=%0d Y=%0d required 2 394", state_dbg, character_Y);
        end
        drive_tick(0, 0, 0, 4'b0000);
        drive_tick(0, 0, 0, 4'b0000);
        n_cmp++;
        if (character_Y !== 10'd395) begin n_err++; $display("FAIL head_hit_vy_zero: got Y=%0d required 395", character_Y); end
        drive_tick(0, 0, 0, 4'b0001);
        n_cmp++;
        if (on_ground !== 1'b1 || character_Y !== 10'd395) begin
            n_err++; $display("FAIL land_on_block: got gnd=%0b Y=%0d required 1 395", on_ground, character_Y);
        end
    endtask

    task automatic test_walk();
        drive_tick(0, 1, 0, 4'b0101);
        n_cmp++;
        if (character_X !== 10'd320 || facing_left !== 1'b0) begin
            n_err++; $display("FAIL walk_blocked_right: got X=%0d face=%0b required 320 0", character_X, facing_left);
        end
        drive_tick(0, 1, 0, 4'b0001);
        n_cmp++;
        if (character_X !== 10'd322 || facing_left !== 1'b0) begin
            n_err++; $display("FAIL walk_right: got X=%0d face=%0b required 322 0", character_X, facing_left);
        end
        drive_tick(1, 0, 0, 4'b0001);
        n_cmp++;
        if (character_X !== 10'd320 || facing_left !== 1'b1) begin
            n_err++; $display("FAIL walk_left: got X=%0d face=%0b required 320 1", character_X, facing_left);
        end
        drive_tick(1, 1, 0, 4'b0001);
        n_cmp++;
        if (character_X !== 10'd320 || facing_left !== 1'b1) begin
            n_err++; $display("FAIL walk_both_keys: got X=%0d face=%0b required 320 1", character_X, facing_left);
        end
        drive_tick(0, 1, 0, 4'b0101);
        n_cmp++;
        if (character_X !== 10'd320 || facing_left !== 1'b1) begin
            n_err++; $display("FAIL walk_blocked_keeps_facing: got X=%0d face=%0b required 320 1", character_X, facing_left);
        end
    endtask

    task automatic test_all_blocked();
        drive_tick(1, 1, 1, 4'b1111);
        n_cmp++;
        if (character_X !== 10'd320 || character_Y !== 10'd395 || state_dbg !== GROUNDED) begin
            n_err++; $display("FAIL all_blocked: got X=%0d Y=%0d st=%0d required 320 395 0", character_X, character_Y, state_dbg);
        end
    endtask

    task automatic test_clamp_x();
        int guard;
        guard = 0;
        while (m_x > 22 && guard < 200) begin drive_tick(1, 0, 0, 4'b0001); guard++; end
        n_cmp++;
        if (character_X !== 10'd22) begin n_err++; $display("FAIL clamp_x_approach: got %0d required 22", character_X); end
        drive_tick(1, 0, 0, 4'b0001);
        n_cmp++;
        if (character_X !== 10'd21) begin n_err++; $display("FAIL clamp_x_first: got %0d required 21", character_X); end
        drive_tick(1, 0, 0, 4'b0001);
        n_cmp++;
        if (character_X !== 10'd21) begin n_err++; $display("FAIL clamp_x_hold: got %0d required 21", character_X); end
    endtask

    task automatic test_walk_off();
        drive_tick(0, 0, 0, 4'b0000);
        n_cmp++;
        if (state_dbg !== FALLING || character_Y !== 10'd395) begin
            n_err++; $display("FAIL walk_off: got st=%0d Y=%0d required 2 395", state_dbg, character_Y);
        end
        drive_tick(0, 0, 0, 4'b0000);
        drive_tick(0, 0, 0, 4'b0000);
        n_cmp++;
        if (character_Y !== 10'd396) begin n_err++; $display("FAIL walk_off_fall: got %0d required 396", character_Y); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 150; i++) begin
            drive_tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        end
    endtask

    task automatic test_reset_mid_rise();
        for (int i = 0; i < 4 && on_ground !== 1'b1; i++) drive_tick(0, 0, 0, 4'b0011);
        drive_tick(0, 1, 1, 4'b0001);
        drive_tick(0, 1, 0, 4'b0000);
        n_cmp++;
        if (state_dbg !== RISING) begin n_err++; $display("FAIL pre_reset_rising: got st=%0d required 1", state_dbg); end
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        n_cmp++;
        if (character_X !== 10'd320 || character_Y !== 10'd240 || state_dbg !== FALLING || on_ground !== 1'b0) begin
            n_err++; $display("FAIL reset_mid_rise: got X=%0d Y=%0d st=%0d gnd=%0b required 320 240 2 0",
                              character_X, character_Y, state_dbg, on_ground);
        end
        @(negedge Clk);
        Reset = 1'b0;
        model_reset();
        exp_q.delete();
        drive_tick(0, 0, 0, 4'b0000);
        drive_tick(0, 0, 0, 4'b0000);
        n_cmp++;
        if (character_Y !== 10'd241) begin n_err++; $display("FAIL after_reset_fall: got %0d required 241", character_Y); end
    endtask

    initial begin
        test_reset();
        test_first_ticks();
        test_free_fall();
        test_jump();
        test_head_hit();
        test_walk();
        test_all_blocked();
        test_clamp_x();
        test_walk_off();
        test_random();
        test_reset_mid_rise();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/character_motion.md
Name: character_motion

Overview:
- Per-frame movement engine for the player sprite.
- Consumes the 4-bit collision vector produced by the bounds/collision judge stage ({left, right, up, down} blocked) together with keyboard intent.
- Produces the registered sprite centre (character_X, character_Y). That centre feeds back into the judge and also drives the sprite renderer.
- Implements walking, jumping, gravity and landing with a 3-state vertical FSM, updated once per frame tick.

Parameters:
- START_X, 320, reset centre X (pixels)
- START_Y, 240, reset centre Y (pixels)
- HALF_W, 21, half sprite width (42/2)
- HALF_H, 28, half sprite height (56/2)
- SCREEN_W, 640, visible width
- SCREEN_H, 480, visible height
- WALK_STEP, 2, horizontal pixels moved per frame
- JUMP_V, 12, initial upward speed (pixels/frame)
- GRAVITY, 1, vertical speed increment per frame
- MAX_FALL, 8, terminal downward speed

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- frame_clk  in  1  vertical-sync-rate strobe (level signal, Clk-domain synchronous)
- key_left  in  1  walk-left request
- key_right  in  1  walk-right request
- key_jump  in  1  jump request
- stop_at  in  4  {left, right, up, down} blocked flags from the judge, for the current position
- character_X  out  10  sprite centre X
- character_Y  out  10  sprite centre Y
- facing_left  out  1  1 = last horizontal motion was leftward
- on_ground  out  1  1 when the FSM is GROUNDED
- frame_tick  out  1  one-Clk pulse; the cycle in which the position update was applied (debug/renderer sync)

Behaviour:
- Reset (async, active-high) sets:
  - character_X = START_X, character_Y = START_Y
  - vy = 0, state = FALLING, facing_left = 0, on_ground = 0, frame_tick = 0
  - frame_clk edge-history register = 0
- Tick generation:
  - frame_clk is registered once.
  - tick = frame_clk & ~frame_clk_q, i.e. rising edge, one Clk wide.
  - All state, position and velocity updates occur only in tick cycles.
  - Outputs are registered, so the new position appears 1 Clk after the tick cycle. frame_tick is asserted in that same output cycle.
- Input sampling: stop_at and the keys are sampled in the tick cycle. stop_at must reflect the current character_X/Y; the judge path is combinational, so no extra latency.
- Horizontal motion (every tick, all states):
  - Move = +WALK_STEP if key_right & ~key_left & ~stop_at[2].
  - Move = -WALK_STEP if key_left & ~key_right & ~stop_at[3].
  - Otherwise move = 0. Both keys pressed gives 0.
  - facing_left updates only when the move is nonzero.
- Vertical speed vy: signed 8-bit. Positions are computed in 11-bit signed, then clamped.
- FSM states: GROUNDED, RISING, FALLING.
  - GROUNDED:
    - key_jump & ~stop_at[1] → RISING; vy = -JUMP_V; Y unchanged this tick.
    - Otherwise, if stop_at[0]=0 and Y < SCREEN_H-1-HALF_H (walked off a ledge) → FALLING; vy = 0.
    - Otherwise stay; vy = 0.
    - Jump takes priority over walk-off.
  - RISING:
    - If stop_at[1] (head hit) → FALLING; vy = 0; Y unchanged.
    - Else Y += vy; vy += GRAVITY.
    - If the new vy >= 0 → FALLING.
  - FALLING:
    - If stop_at[0], or Y >= SCREEN_H-1-HALF_H → GROUNDED; vy = 0; Y unchanged (landing).
    - Else Y += vy; vy = min(vy+GRAVITY, MAX_FALL).
- Clamping (applied after every update):
  - X in [HALF_W, SCREEN_W-1-HALF_W] = [21, 618].
  - Y in [HALF_H, SCREEN_H-1-HALF_H] = [28, 451].
  - A Y clamp at the top during RISING forces vy = 0 and state FALLING.
  - No wrap-around ever.
- Simultaneous events:
  - Left and up blocked together while rising: horizontal and vertical rules apply independently.
  - stop_at = 4'b1111 with all keys pressed: the sprite stays put; the FSM goes to or stays GROUNDED/FALLING per the rules above.
- Reset mid-jump: immediate return to reset values. The next tick is treated as the first.
- Between ticks, all outputs hold.

Decomposition:
- Package feppagia_pkg holds:
  - typedef enum logic [1:0] motion_state_t {GROUNDED, RISING, FALLING}
  - sprite constants SPRITE_W=42, SPRITE_H=56
  - SCREEN_W, SCREEN_H
  - These are shared with the judge and the renderer.
- One sub-module: frame_tick_gen (frame_clk rising-edge detector → single-cycle tick).

Test Plan:
- Reset → X=320, Y=240, vy=0, FALLING, on_ground=0. First tick (stop_at=0): Y=240, vy=1. Second tick: Y=241, vy=2.
- Free fall from Y=240, no blocks → vy saturates at 8 after 8 ticks. Y is clamped at 451, then GROUNDED on the following tick with on_ground=1.
- GROUNDED at Y=400, stop_at=4'b0001, key_jump=1 → tick1: RISING, Y=400, vy=-12; tick2: Y=388, vy=-11; tick3: Y=377, vy=-10.
- RISING at Y=300, vy=-6, stop_at[1]=1 → next tick: FALLING, vy=0, Y=300.
- GROUNDED at X=100, key_right=1, stop_at=4'b0101 → X stays 100 and facing_left unchanged. With stop_at=4'b0001 → X=102, facing_left=0. key_left+key_right → X unchanged.
- X=22, key_left held for 2 ticks → X=21 then 21 (clamp). Assert Reset mid-RISING → X=320, Y=240 immediately, FALLING.
